// File: rtl/ndma_pkg.sv
// Shared widths, command record and write-FSM state encoding for the NDMA write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ndma_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   // Write issue sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2
   } wr_state_e;

   // One buffered write command, as accepted from the DMA core.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/obi_bus.sv
// OBI request/response bundle with manager and subordinate views.
// Latency: n/a (wires only).
// Backpressure: req/gnt on the address phase, rvalid/rready on the response phase.
interface OBI_BUS;
   import ndma_pkg::*;

   // Address phase
   logic              req;
   logic              reqpar;
   logic              gnt;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;
   logic              aid;
   logic              a_optional;

   // Response phase
   logic              rvalid;
   logic              rready;
   logic              rreadypar;
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic              rid;

   modport Manager (
      output req, reqpar, addr, we, be, wdata, aid, a_optional, rready, rreadypar,
      input  gnt, rvalid, rdata, err, rid
   );

   modport Subordinate (
      input  req, reqpar, addr, we, be, wdata, aid, a_optional, rready, rreadypar,
      output gnt, rvalid, rdata, err, rid
   );

endinterface

// File: rtl/ndma_fifo.sv
// Generic synchronous FIFO with first-word-fall-through head and occupancy count.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module ndma_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count_o    = wr_ptr_q - rd_ptr_q;
   assign full_o     = (count_o == DEPTH_C);
   assign empty_o    = (count_o == '0);
   assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Advance read/write pointers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
   end

endmodule

// File: rtl/ndma_write_mgr.sv
// Buffers DMA write commands and issues them as OBI writes, bounding writes awaiting response.
// Latency: command accepted in cycle N with empty buffer and idle sequencer -> req in cycle N+1.
// Backpressure: ready_o low while the buffer is full; issue stalls at MAX_OUT outstanding writes.
module ndma_write_mgr
   import ndma_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int MAX_OUT = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [BE_W-1:0]   be_i,
   output logic              ready_o,
   output logic              done_o,
   output logic              err_o,
   input  logic              err_clr_i,
   output logic              busy_o,
   OBI_BUS.Manager           write_mgr
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int OUT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [OUT_W-1:0] OUT_ONE   = OUT_W'(1);
   localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

   cmd_t             push_cmd;
   cmd_t             head_cmd;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_cnt;
   logic [CNT_W-1:0] fifo_cnt_nxt;

   logic             push;
   logic             pop;
   logic             rsp_acc;
   logic             more_cmds;
   logic             below_limit;

   wr_state_e        state_q;
   logic [OUT_W-1:0] out_q;
   logic [OUT_W-1:0] out_d;
   logic             err_q;
   logic             err_d;

   logic             unused_rsp;

   // ---------------------------------------------------------------
   // Command buffer
   // ---------------------------------------------------------------
   assign ready_o  = !fifo_full;
   assign push     = req_i && ready_o;
   assign push_cmd = '{addr: addr_i, wdata: wdata_i, be: be_i};

   ndma_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push),
      .push_dat_i (push_cmd),
      .pop_i      (pop),
      .head_dat_o (head_cmd),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_cnt)
   );

   // ---------------------------------------------------------------
   // Handshake events
   // ---------------------------------------------------------------
   // The head leaves the buffer on the address-phase handshake.
   assign pop = (state_q == ST_ADDR) && write_mgr.gnt;

   // Responses with nothing outstanding are stray and must not underflow the count.
   assign rsp_acc = write_mgr.rvalid && (out_q != '0);

   // Buffer occupancy after this cycle's push/pop; includes a same-cycle push so a
   // command arriving at an idle block is issued on the very next cycle.
   always_comb begin
      fifo_cnt_nxt = fifo_cnt;
      if (push) fifo_cnt_nxt = fifo_cnt_nxt + CNT_ONE;
      if (pop)  fifo_cnt_nxt = fifo_cnt_nxt - CNT_ONE;
   end

   // Outstanding-write count after this cycle; grant and response together cancel.
   always_comb begin
      out_d = out_q;
      if (pop && !rsp_acc) begin
         out_d = out_q + OUT_ONE;
      end else if (!pop && rsp_acc) begin
         out_d = out_q - OUT_ONE;
      end
   end

   assign more_cmds   = (fifo_cnt_nxt != '0);
   assign below_limit = (out_d < MAX_OUT_C);

   // Sticky error: a new error wins over a same-cycle clear.
   always_comb begin
      err_d = err_q;
      if (rsp_acc && write_mgr.err) begin
         err_d = 1'b1;
      end else if (err_clr_i) begin
         err_d = 1'b0;
      end
   end

   // Outstanding counter and error flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q <= '0;
         err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         err_q <= err_d;
      end
   end

   // Issue sequencer: present the buffer head whenever the response window has room.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (more_cmds) state_q <= below_limit ? ST_ADDR : ST_WAIT;
            end
            ST_ADDR: begin
               if (pop) begin
                  if (!more_cmds) state_q <= ST_IDLE;
                  else            state_q <= below_limit ? ST_ADDR : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (below_limit) state_q <= more_cmds ? ST_ADDR : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // OBI manager drive; payload comes straight from the buffer head,
   // which cannot move until the grant pops it.
   // ---------------------------------------------------------------
   assign write_mgr.req        = (state_q == ST_ADDR);
   assign write_mgr.addr       = head_cmd.addr;
   assign write_mgr.wdata      = head_cmd.wdata;
   assign write_mgr.be         = head_cmd.be;
   assign write_mgr.we         = 1'b1;
   assign write_mgr.reqpar     = 1'b0;
   assign write_mgr.aid        = 1'b0;
   assign write_mgr.a_optional = 1'b0;
   assign write_mgr.rready     = 1'b1;
   assign write_mgr.rreadypar  = 1'b0;

   // Write responses carry no data of interest.
   assign unused_rsp = ^{write_mgr.rdata, write_mgr.rid};

   // ---------------------------------------------------------------
   // Status
   // ---------------------------------------------------------------
   assign done_o = rsp_acc;
   assign err_o  = err_q;
   assign busy_o = !fifo_empty || (state_q != ST_IDLE) || (out_q != '0);

endmodule

// File: tb/tb_ndma_write_mgr.sv
// Randomized scoreboard bench for ndma_write_mgr against a transaction-level model.
// Latency: n/a.
// Backpressure: gnt/rvalid randomized per phase, including long stalls and resets.
module tb_ndma_write_mgr;
   import ndma_pkg::*;

   localparam int DEPTH   = 2;
   localparam int MAX_OUT = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req = 1'b0;
   logic [ADDR_W-1:0] addr = '0;
   logic [DATA_W-1:0] wdata = '0;
   logic [BE_W-1:0]   be = '0;
   logic              err_clr = 1'b0;
   logic              ready;
   logic              done;
   logic              err;
   logic              busy;
   logic              end_chk = 1'b0;

   OBI_BUS obi_if ();

   ndma_write_mgr #(
      .DEPTH   (DEPTH),
      .MAX_OUT (MAX_OUT)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .be_i      (be),
      .ready_o   (ready),
      .done_o    (done),
      .err_o     (err),
      .err_clr_i (err_clr),
      .busy_o    (busy),
      .write_mgr (obi_if)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: commands accepted but not yet granted (in order), writes granted but
   // not yet answered, and the sticky error bit.
   cmd_t exp_q[$];
   int   out_m = 0;
   bit   err_m = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor / scoreboard: sample mid-cycle, compare, then advance the model.
   always @(negedge clk) begin
      bit   rsp_ok;
      cmd_t c;
      if (rst) begin
         exp_q.delete();
         out_m = 0;
         err_m = 1'b0;
      end else begin
         check("ready_o", 32'(ready), 32'(exp_q.size() < DEPTH));
         check("busy_o", 32'(busy), 32'((exp_q.size() != 0) || (out_m != 0)));
         // Work-conserving issue: a request is up exactly when something is queued
         // and the response window has room.
         check("req", 32'(obi_if.req), 32'((exp_q.size() != 0) && (out_m < MAX_OUT)));
         check("err_o", 32'(err), 32'(err_m));
         check("ties", 32'({obi_if.we, obi_if.rready, obi_if.reqpar,
                            obi_if.rreadypar, obi_if.aid, obi_if.a_optional}), 32'h30);
         if (obi_if.req && (exp_q.size() != 0)) begin
            check("addr", obi_if.addr, exp_q[0].addr);
            check("wdata", obi_if.wdata, exp_q[0].wdata);
            check("be", 32'(obi_if.be), 32'(exp_q[0].be));
         end

         rsp_ok = obi_if.rvalid && (out_m > 0);
         check("done_o", 32'(done), 32'(rsp_ok));

         if (obi_if.req && obi_if.gnt) begin
            check("grant_limit", 32'(out_m < MAX_OUT), 32'd1);
            check("grant_has_cmd", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            out_m++;
         end
         if (rsp_ok) out_m--;

         if (rsp_ok && obi_if.err) err_m = 1'b1;
         else if (err_clr)         err_m = 1'b0;

         // Commands the DUT takes this cycle become expected bus transfers.
         if (req && ready) begin
            c.addr  = addr;
            c.wdata = wdata;
            c.be    = be;
            exp_q.push_back(c);
         end

         if (end_chk) begin
            check("drain_busy", 32'(busy), 32'd0);
            check("drain_ready", 32'(ready), 32'd1);
         end
      end
   end

   // One cycle of random stimulus, percentages per signal.
   task automatic drive_cycle(input int p_req, input int p_gnt, input int p_rv,
                              input int p_err, input int p_clr);
      req          = ($urandom_range(99) < p_req);
      addr         = $urandom;
      wdata        = $urandom;
      be           = 4'($urandom);
      obi_if.gnt   = ($urandom_range(99) < p_gnt);
      obi_if.rvalid = ($urandom_range(99) < p_rv);
      obi_if.err   = ($urandom_range(99) < p_err);
      obi_if.rdata = $urandom;
      err_clr      = ($urandom_range(99) < p_clr);
      @(posedge clk);
      #1;
   endtask

   task automatic run_phase(input int len, input int p_req, input int p_gnt, input int p_rv,
                            input int p_err, input int p_clr, input bit rst_after);
      for (int c = 0; c < len; c++) drive_cycle(p_req, p_gnt, p_rv, p_err, p_clr);
      if (rst_after) begin
         rst = 1'b1;
         req = 1'b0;
         @(posedge clk);
         #1;
         rst = 1'b0;
      end
   endtask

   initial begin
      obi_if.gnt    = 1'b0;
      obi_if.rvalid = 1'b0;
      obi_if.err    = 1'b0;
      obi_if.rdata  = '0;
      obi_if.rid    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      //         len  req  gnt  rv  err  clr  rst
      run_phase(   4,   0,   0,   0,   0,   0, 1'b0);  // idle after reset
      run_phase( 200,  50,  50,  30,   0,   0, 1'b0);  // mixed traffic
      run_phase(  30, 100, 100,   0,   0,   0, 1'b0);  // responses withheld: window fills
      run_phase( 100,  30, 100,  20,   0,   0, 1'b0);  // slow responses
      run_phase( 200,  80,  20,  50,  30,  10, 1'b0);  // heavy backpressure, errors
      run_phase( 200,  60,  60,  60,  50,  50, 1'b0);  // error/clear collisions
      run_phase(  15,   0, 100, 100,   0,   0, 1'b0);  // drain
      run_phase(  10, 100,   0,   0,   0,   0, 1'b1);  // fill and stall, reset mid-request
      run_phase(   5,   0,   0, 100, 100,   0, 1'b0);  // late responses after reset
      run_phase( 300,  70,  70,  70,  10,   5, 1'b1);  // random, then reset
      run_phase( 300,  50,  80,  40,  20,   5, 1'b0);  // random
      run_phase(  40,   0, 100, 100,   0,   0, 1'b0);  // final drain

      req           = 1'b0;
      obi_if.gnt    = 1'b0;
      obi_if.rvalid = 1'b0;
      err_clr       = 1'b0;
      end_chk       = 1'b1;
      @(posedge clk);
      #1;
      end_chk = 1'b0;
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
